// File: rtl/dbus_arbiter.sv
// Two-master arbiter for the unified memory bus.
// Master 0 is the fetch-side port and master 1 is the memory-stage data port.
// The winning request is latched so the downstream bus sees stable fields.
// The grant is held until s_data_ok; handshakes are routed only to the granted master.
module dbus_arbiter #(
    parameter int ADDR_W  = 64,
    parameter int DATA_W  = 64,
    parameter int RR_MODE = 0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                m0_valid,
    input  logic [ADDR_W-1:0]   m0_addr,
    input  logic [2:0]          m0_size,
    input  logic [DATA_W/8-1:0] m0_strobe,
    input  logic [DATA_W-1:0]   m0_wdata,
    output logic                m0_addr_ok,
    output logic                m0_data_ok,
    output logic [DATA_W-1:0]   m0_rdata,
    input  logic                m1_valid,
    input  logic [ADDR_W-1:0]   m1_addr,
    input  logic [2:0]          m1_size,
    input  logic [DATA_W/8-1:0] m1_strobe,
    input  logic [DATA_W-1:0]   m1_wdata,
    output logic                m1_addr_ok,
    output logic                m1_data_ok,
    output logic [DATA_W-1:0]   m1_rdata,
    output logic                s_valid,
    output logic [ADDR_W-1:0]   s_addr,
    output logic [2:0]          s_size,
    output logic [DATA_W/8-1:0] s_strobe,
    output logic [DATA_W-1:0]   s_wdata,
    input  logic                s_addr_ok,
    input  logic                s_data_ok,
    input  logic [DATA_W-1:0]   s_rdata
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  r_grant;
    logic                  r_last;
    logic                  w_winner;
    logic                  w_start;
    logic [ADDR_W-1:0]     r_addr;
    logic [2:0]            r_size;
    logic [DATA_W/8-1:0]   r_strobe;
    logic [DATA_W-1:0]     r_wdata;

    assign w_start = (r_state == IDLE) && (m0_valid || m1_valid);

    // Pick the winner: master 1 by default, the master not served last on a round-robin collision
    always_comb begin
        w_winner = m1_valid;
        if ((RR_MODE != 0) && m0_valid && m1_valid) begin
            w_winner = ~r_last;
        end
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Latch the winning request and track grant / last-served master
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_grant  <= 1'b0;
            r_last   <= 1'b1;
            r_addr   <= '0;
            r_size   <= '0;
            r_strobe <= '0;
            r_wdata  <= '0;
        end else if (w_start) begin
            r_grant  <= w_winner;
            r_addr   <= w_winner ? m1_addr   : m0_addr;
            r_size   <= w_winner ? m1_size   : m0_size;
            r_strobe <= w_winner ? m1_strobe : m0_strobe;
            r_wdata  <= w_winner ? m1_wdata  : m0_wdata;
        end else if ((r_state == BUSY) && s_data_ok) begin
            r_last <= r_grant;
        end
    end

    // Next-state logic and handshake routing to the granted master
    always_comb begin
        w_state_nxt = r_state;
        s_valid     = 1'b0;
        m0_addr_ok  = 1'b0;
        m0_data_ok  = 1'b0;
        m0_rdata    = '0;
        m1_addr_ok  = 1'b0;
        m1_data_ok  = 1'b0;
        m1_rdata    = '0;
        case (r_state)
            IDLE: begin
                if (m0_valid || m1_valid) begin
                    w_state_nxt = BUSY;
                end
            end
            BUSY: begin
                s_valid = 1'b1;
                if (r_grant) begin
                    m1_addr_ok = s_addr_ok;
                    m1_data_ok = s_data_ok;
                    m1_rdata   = s_rdata;
                end else begin
                    m0_addr_ok = s_addr_ok;
                    m0_data_ok = s_data_ok;
                    m0_rdata   = s_rdata;
                end
                if (s_data_ok) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign s_addr   = r_addr;
    assign s_size   = r_size;
    assign s_strobe = r_strobe;
    assign s_wdata  = r_wdata;

endmodule

// File: tb/tb_dbus_arbiter.sv
// Bench for dbus_arbiter: one instance per arbitration mode sharing the same stimulus.
module tb_dbus_arbiter;

    localparam logic [63:0] A0 = 64'h0000_0000_8000_0000;
    localparam logic [63:0] A1 = 64'h0000_0000_0000_0010;
    localparam logic [63:0] RD = 64'h1122_3344_5566_7788;

    logic        clk = 1'b0;
    logic        reset;
    logic        m0_valid, m1_valid;
    logic [63:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
    logic [2:0]  m0_size, m1_size;
    logic [7:0]  m0_strobe, m1_strobe;
    logic        s_addr_ok, s_data_ok;
    logic [63:0] s_rdata;

    logic [1:0]        o_sv, o_m0a, o_m0d, o_m1a, o_m1d;
    logic [1:0][63:0]  o_sa, o_sw, o_r0, o_r1;
    logic [1:0][2:0]   o_ss;
    logic [1:0][7:0]   o_sst;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        dbus_arbiter #(.ADDR_W(64), .DATA_W(64), .RR_MODE(g)) u_dut (
            .clk(clk), .reset(reset),
            .m0_valid(m0_valid), .m0_addr(m0_addr), .m0_size(m0_size),
            .m0_strobe(m0_strobe), .m0_wdata(m0_wdata),
            .m0_addr_ok(o_m0a[g]), .m0_data_ok(o_m0d[g]), .m0_rdata(o_r0[g]),
            .m1_valid(m1_valid), .m1_addr(m1_addr), .m1_size(m1_size),
            .m1_strobe(m1_strobe), .m1_wdata(m1_wdata),
            .m1_addr_ok(o_m1a[g]), .m1_data_ok(o_m1d[g]), .m1_rdata(o_r1[g]),
            .s_valid(o_sv[g]), .s_addr(o_sa[g]), .s_size(o_ss[g]),
            .s_strobe(o_sst[g]), .s_wdata(o_sw[g]),
            .s_addr_ok(s_addr_ok), .s_data_ok(s_data_ok), .s_rdata(s_rdata)
        );
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic idle_inputs();
        m0_valid = 0; m1_valid = 0;
        m0_addr = A0; m1_addr = A1;
        m0_size = 3'd3; m1_size = 3'd2;
        m0_strobe = '0; m1_strobe = '0;
        m0_wdata = '0; m1_wdata = '0;
        s_addr_ok = 0; s_data_ok = 0; s_rdata = RD;
    endtask

    // Reset both instances, check the reset state, release on a falling edge
    task automatic do_reset();
        idle_inputs();
        reset = 1'b0;
        @(negedge clk);
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("rst_svalid%0d", k), {63'd0, o_sv[k]}, 64'd0);
            chk($sformatf("rst_ok%0d", k), {60'd0, o_m0a[k], o_m0d[k], o_m1a[k], o_m1d[k]}, 64'd0);
            chk($sformatf("rst_saddr%0d", k), o_sa[k], 64'd0);
            chk($sformatf("rst_sstrobe%0d", k), {56'd0, o_sst[k]}, 64'd0);
            chk($sformatf("rst_rdata%0d", k), o_r0[k] | o_r1[k], 64'd0);
        end
        reset = 1'b1;
    endtask

    typedef struct {
        bit m0v, m1v, aok, dok;
        bit e_sv, e_m0a, e_m0d, e_m1a, e_m1d;
        int e_own; // 0 none, 1 master 0, 2 master 1
    } vec_t;

    typedef struct {
        bit          busy;
        bit          own;
        bit          last;
        logic [63:0] addr;
        logic [2:0]  size;
        logic [7:0]  strb;
        logic [63:0] wdata;
    } mdl_t;

    mdl_t mdl[2];

    vec_t tbl[15];
    int   got[$];

    initial begin
        // Fixed-priority instance: single read, collisions, simultaneous ok pulses, idle ok pulses
        tbl[0]  = '{1,0,0,0, 0,0,0,0,0, 0};
        tbl[1]  = '{1,0,1,0, 1,1,0,0,0, 1};
        tbl[2]  = '{1,0,0,0, 1,0,0,0,0, 1};
        tbl[3]  = '{1,0,0,1, 1,0,1,0,0, 1};
        tbl[4]  = '{0,0,0,0, 0,0,0,0,0, 0};
        tbl[5]  = '{1,1,0,0, 0,0,0,0,0, 0};
        tbl[6]  = '{1,1,1,0, 1,0,0,1,0, 2};
        tbl[7]  = '{1,1,0,1, 1,0,0,0,1, 2};
        tbl[8]  = '{1,1,0,0, 0,0,0,0,0, 0};
        tbl[9]  = '{1,1,1,0, 1,0,0,1,0, 2};
        tbl[10] = '{1,1,0,1, 1,0,0,0,1, 2};
        tbl[11] = '{1,0,0,0, 0,0,0,0,0, 0};
        tbl[12] = '{1,0,1,1, 1,1,1,0,0, 1};
        tbl[13] = '{0,0,1,1, 0,0,0,0,0, 0};
        tbl[14] = '{0,0,0,0, 0,0,0,0,0, 0};

        do_reset();
        for (int i = 0; i < 15; i++) begin
            m0_valid = tbl[i].m0v; m1_valid = tbl[i].m1v;
            s_addr_ok = tbl[i].aok; s_data_ok = tbl[i].dok;
            #4;
            chk($sformatf("tbl%0d_svalid", i), {63'd0, o_sv[0]}, {63'd0, tbl[i].e_sv});
            chk($sformatf("tbl%0d_m0aok", i), {63'd0, o_m0a[0]}, {63'd0, tbl[i].e_m0a});
            chk($sformatf("tbl%0d_m0dok", i), {63'd0, o_m0d[0]}, {63'd0, tbl[i].e_m0d});
            chk($sformatf("tbl%0d_m1aok", i), {63'd0, o_m1a[0]}, {63'd0, tbl[i].e_m1a});
            chk($sformatf("tbl%0d_m1dok", i), {63'd0, o_m1d[0]}, {63'd0, tbl[i].e_m1d});
            chk($sformatf("tbl%0d_m0rdata", i), o_r0[0], (tbl[i].e_own == 1) ? RD : 64'd0);
            chk($sformatf("tbl%0d_m1rdata", i), o_r1[0], (tbl[i].e_own == 2) ? RD : 64'd0);
            if (tbl[i].e_own != 0)
                chk($sformatf("tbl%0d_saddr", i), o_sa[0], (tbl[i].e_own == 1) ? A0 : A1);
            @(negedge clk);
        end

        // Round-robin instance: continuous collision alternates m0, m1, m0
        do_reset();
        m0_valid = 1; m1_valid = 1;
        got.delete();
        for (int c = 0; c < 40 && got.size() < 3; c++) begin
            s_data_ok = o_sv[1];
            #4;
            if (o_m0d[1]) got.push_back(0);
            else if (o_m1d[1]) got.push_back(1);
            @(negedge clk);
        end
        chk("rr_grant_count", got.size(), 64'd3);
        for (int i = 0; i < 3; i++)
            chk($sformatf("rr_grant%0d", i), (i < got.size()) ? got[i] : 9, i % 2);

        // Stability: latched m1 write must not follow master input changes
        do_reset();
        m1_valid = 1; m1_addr = 64'h10; m1_strobe = 8'h0F; m1_wdata = 64'hAA;
        #4 chk("stab_idle_svalid", {63'd0, o_sv[0]}, 64'd0);
        @(negedge clk);
        m1_addr = 64'h20; m1_strobe = 8'hF0; m1_wdata = 64'h55;
        for (int c = 0; c < 2; c++) begin
            #4;
            chk("stab_svalid", {63'd0, o_sv[0]}, 64'd1);
            chk("stab_saddr", o_sa[0], 64'h10);
            chk("stab_sstrobe", {56'd0, o_sst[0]}, 64'h0F);
            chk("stab_swdata", o_sw[0], 64'hAA);
            @(negedge clk);
        end
        s_data_ok = 1;
        #4 chk("stab_m1dok", {63'd0, o_m1d[0]}, 64'd1);
        chk("stab_saddr_last", o_sa[0], 64'h10);
        @(negedge clk);
        s_data_ok = 0; m1_valid = 0;

        // Flush: m0 drops valid mid-transaction, transaction still completes
        do_reset();
        m0_valid = 1;
        @(negedge clk);
        m0_valid = 0;
        for (int c = 0; c < 2; c++) begin
            #4 chk("flush_svalid", {63'd0, o_sv[0]}, 64'd1);
            @(negedge clk);
        end
        s_data_ok = 1;
        #4 chk("flush_m0dok", {63'd0, o_m0d[0]}, 64'd1);
        chk("flush_m1dok", {63'd0, o_m1d[0]}, 64'd0);
        @(negedge clk);
        s_data_ok = 0;
        #4 chk("flush_idle_after", {63'd0, o_sv[0]}, 64'd0);
        @(negedge clk);

        // Asynchronous reset mid-transaction
        do_reset();
        m1_valid = 1; m1_addr = 64'h30;
        @(negedge clk);
        #2 chk("arst_busy", {63'd0, o_sv[0]}, 64'd1);
        reset = 0;
        #1 chk("arst_drop0", {63'd0, o_sv[0]}, 64'd0);
        chk("arst_drop1", {63'd0, o_sv[1]}, 64'd0);
        @(negedge clk);
        reset = 1;
        #4 chk("arst_idle", {63'd0, o_sv[0]}, 64'd0);
        @(negedge clk);
        s_addr_ok = 1;
        #4 chk("arst_regrant_sv", {63'd0, o_sv[0]}, 64'd1);
        chk("arst_regrant_m1aok", {63'd0, o_m1a[0]}, 64'd1);
        chk("arst_regrant_saddr", o_sa[0], 64'h30);
        @(negedge clk);

        // Randomized traffic against a transaction-level model for both modes
        do_reset();
        for (int k = 0; k < 2; k++) mdl[k] = '{0, 0, 1, '0, '0, '0, '0};
        for (int c = 0; c < 600; c++) begin
            m0_valid  = ($urandom_range(0, 3) != 0);
            m1_valid  = ($urandom_range(0, 2) == 0);
            m0_addr   = {$urandom, $urandom}; m1_addr  = {$urandom, $urandom};
            m0_wdata  = {$urandom, $urandom}; m1_wdata = {$urandom, $urandom};
            m0_size   = 3'($urandom);          m1_size  = 3'($urandom);
            m0_strobe = 8'($urandom);          m1_strobe = 8'($urandom);
            s_addr_ok = ($urandom_range(0, 1) == 1);
            s_data_ok = ($urandom_range(0, 2) == 0);
            s_rdata   = {$urandom, $urandom};
            #4;
            for (int k = 0; k < 2; k++) begin
                logic g0, g1;
                g0 = mdl[k].busy && !mdl[k].own;
                g1 = mdl[k].busy && mdl[k].own;
                chk($sformatf("rnd%0d_svalid", k), {63'd0, o_sv[k]}, {63'd0, mdl[k].busy});
                chk($sformatf("rnd%0d_m0aok", k), {63'd0, o_m0a[k]}, {63'd0, g0 & s_addr_ok});
                chk($sformatf("rnd%0d_m0dok", k), {63'd0, o_m0d[k]}, {63'd0, g0 & s_data_ok});
                chk($sformatf("rnd%0d_m1aok", k), {63'd0, o_m1a[k]}, {63'd0, g1 & s_addr_ok});
                chk($sformatf("rnd%0d_m1dok", k), {63'd0, o_m1d[k]}, {63'd0, g1 & s_data_ok});
                chk($sformatf("rnd%0d_m0rdata", k), o_r0[k], g0 ? s_rdata : 64'd0);
                chk($sformatf("rnd%0d_m1rdata", k), o_r1[k], g1 ? s_rdata : 64'd0);
                if (mdl[k].busy) begin
                    chk($sformatf("rnd%0d_saddr", k), o_sa[k], mdl[k].addr);
                    chk($sformatf("rnd%0d_ssize", k), {61'd0, o_ss[k]}, {61'd0, mdl[k].size});
                    chk($sformatf("rnd%0d_sstrobe", k), {56'd0, o_sst[k]}, {56'd0, mdl[k].strb});
                    chk($sformatf("rnd%0d_swdata", k), o_sw[k], mdl[k].wdata);
                end
            end
            @(posedge clk);
            for (int k = 0; k < 2; k++) begin
                if (!mdl[k].busy) begin
                    if (m0_valid || m1_valid) begin
                        bit w;
                        if (k == 1 && m0_valid && m1_valid) w = !mdl[k].last;
                        else w = m1_valid;
                        mdl[k].busy  = 1;
                        mdl[k].own   = w;
                        mdl[k].addr  = w ? m1_addr : m0_addr;
                        mdl[k].size  = w ? m1_size : m0_size;
                        mdl[k].strb  = w ? m1_strobe : m0_strobe;
                        mdl[k].wdata = w ? m1_wdata : m0_wdata;
                    end
                end else if (s_data_ok) begin
                    mdl[k].last = mdl[k].own;
                    mdl[k].busy = 0;
                end
            end
            @(negedge clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dbus_arbiter.md
Name: dbus_arbiter

Overview:
Two-master arbiter that shares one unified memory bus between the fetch-side request port (master 0) and the memory-stage data port (master 1).
- Grants one master at a time.
- Latches the winning request so the downstream bus sees it stable.
- Holds the grant until the downstream returns data_ok.
- Routes the handshake back only to the granted master.
- Sits between the pipeline's bus ports and the cache/memory interface.

Parameters:
ADDR_W, 64, request address width
DATA_W, 64, data width (strobe is DATA_W/8 bits)
RR_MODE, 0, 0 = fixed priority (master 1 wins), 1 = round-robin (master not served last wins)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
m0_valid  in  1  master 0 request valid; held until m0_data_ok
m0_addr  in  ADDR_W  master 0 address
m0_size  in  3  master 0 access size code
m0_strobe  in  DATA_W/8  master 0 byte write enables; 0 means read
m0_wdata  in  DATA_W  master 0 write data
m0_addr_ok  out  1  master 0 address accepted
m0_data_ok  out  1  master 0 transaction complete
m0_rdata  out  DATA_W  master 0 read data
m1_valid, m1_addr, m1_size, m1_strobe, m1_wdata  in  as master 0  master 1 request
m1_addr_ok, m1_data_ok, m1_rdata  out  as master 0  master 1 response
s_valid  out  1  downstream request valid
s_addr  out  ADDR_W  downstream address
s_size  out  3  downstream size
s_strobe  out  DATA_W/8  downstream strobe
s_wdata  out  DATA_W  downstream write data
s_addr_ok  in  1  downstream address accepted
s_data_ok  in  1  downstream transaction complete
s_rdata  in  DATA_W  downstream read data

Behaviour:
- State machine: IDLE, BUSY. Registers: state, grant (1 bit), last (1 bit), and a latched request (addr/size/strobe/wdata).
- Reset (reset=0, async): state=IDLE, grant=0, last=1, latched request=0. All outputs 0.
- IDLE:
  - s_valid=0; all m*_addr_ok and m*_data_ok are 0.
  - If any m*_valid is high: pick a winner, latch its fields, set grant=winner, go to BUSY next cycle.
- Arbitration:
  - RR_MODE=0: master 1 wins whenever m1_valid=1.
  - RR_MODE=1: if both masters request, the winner is !last. A single requester always wins.
- BUSY:
  - s_valid=1; s_* are driven from the latched registers. They must not change while BUSY, even if the master's inputs change.
  - m[grant]_addr_ok = s_addr_ok and m[grant]_data_ok = s_data_ok, both combinational pass-through.
  - m[grant]_rdata = s_rdata.
  - The other master's ok signals are 0.
  - On s_data_ok=1: set last=grant and go to IDLE next cycle.
- Latency: one IDLE cycle between a request appearing and s_valid. One IDLE bubble after every completion, so back-to-back transactions are separated by at least 1 cycle.
- m*_rdata of the non-granted master, and of both masters in IDLE, is 0.
- Granted master drops valid mid-BUSY (flush):
  - The downstream transaction still runs to s_data_ok; it is never aborted.
  - data_ok is still pulsed to that master, which ignores it.
- Non-granted master asserting valid during BUSY waits; it is not acknowledged.
- s_addr_ok and s_data_ok in the same cycle is legal; both pass through.
- s_addr_ok/s_data_ok while IDLE are ignored (no output, no state change).
- Reset asserted mid-BUSY: immediate return to IDLE, s_valid drops asynchronously, the transaction is lost.

Test Plan:
- Single read: m0_valid=1, addr=0x8000_0000, strobe=0. Expect s_valid at cycle 2 with s_addr=0x8000_0000. Downstream returns data_ok with rdata=0x1122334455667788 at cycle 4 → m0_data_ok=1 with that rdata in the same cycle; m1 ok=0; state IDLE at cycle 5.
- Collision, RR_MODE=0: both valid every cycle, downstream takes 2 cycles per access. Grants are m1, m1, m1…; m0 is never granted while m1 stays valid. Once m1 drops, m0 is granted after one IDLE cycle.
- Collision, RR_MODE=1: both valid continuously. Grants alternate m0, m1, m0 (last=1 after reset, so m0 first).
- Stability: during BUSY for an m1 write (addr 0x10, strobe 0x0F, wdata 0xAA), change m1_addr to 0x20. s_addr stays 0x10 and s_strobe stays 0x0F until data_ok.
- Flush: m0 granted, m0_valid deasserted in BUSY. s_valid stays 1 until s_data_ok; m0_data_ok pulses; the next cycle is IDLE.
- Async reset: assert reset=0 mid-BUSY between clock edges. s_valid goes to 0 immediately; after release, state is IDLE and a new m1 request is granted normally.
